// File: rtl/gold_scrambler.sv
// Gold-sequence (length-31 LFSR pair) bit scrambler with valid/ready in and out.
// Optional macro SCR_SEQ_OUT_EN adds the gold_bit output carrying c(n) per accepted bit.
module gold_scrambler #(
  parameter int NC      = 1600,
  parameter int SEQ_LEN = 1920
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [30:0] seed,
  input  logic        seed_valid,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
`ifdef SCR_SEQ_OUT_EN
  ,
  output logic        gold_bit
`endif
);

  localparam int CNT_MAX = (NC > SEQ_LEN) ? NC : SEQ_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] NC_LAST  = (NC > 0) ? CNT_W'(NC - 1) : '0;
  localparam logic [CNT_W-1:0] SEQ_LAST = (SEQ_LEN > 0) ? CNT_W'(SEQ_LEN - 1) : '0;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t           state;
  logic [30:0]      x1;
  logic [30:0]      x2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  function automatic logic [30:0] x1_next(input logic [30:0] x);
    return {x[3] ^ x[0], x[30:1]};
  endfunction

  function automatic logic [30:0] x2_next(input logic [30:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
  endfunction

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x1        <= '0;
      x2        <= '0;
      cnt       <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SCR_SEQ_OUT_EN
      gold_bit  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // Output register drains independently of state; a new accept below overrides.
      if (out_ready && !accept)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_valid) begin
            x1    <= 31'h0000_0001;
            x2    <= seed;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (NC == 0) ? RUN : WARMUP;
          end
        end
        WARMUP: begin
          x1 <= x1_next(x1);
          x2 <= x2_next(x2);
          if (cnt == NC_LAST) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            out_bit   <= in_bit ^ x1[0] ^ x2[0];
            out_valid <= 1'b1;
`ifdef SCR_SEQ_OUT_EN
            gold_bit  <= x1[0] ^ x2[0];
`endif
            x1 <= x1_next(x1);
            x2 <= x2_next(x2);
            if (cnt == SEQ_LAST) begin
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/gold_scrambler.md
# gold_scrambler

Transmit-side counterpart of the PBCH descrambling path: generates the 3GPP length-31 Gold sequence c(n) = x1(n+NC) xor x2(n+NC) from a 31-bit c_init and XORs it onto an incoming bit stream, producing scrambled bits. Sits between the rate-matching output and the modulation mapper in the test-vector/loopback transmitter. It is used to produce reference streams for the MIB decoding receiver.

## Interface

- NC, 1600, Gold sequence offset (warm-up shifts before first output bit); 0 permitted.
- SEQ_LEN, 1920, bits scrambled per seed (PBCH, normal CP).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- seed  input  31  c_init; seed[0] loads x2(0), seed[30] loads x2(30).
- seed_valid  input  1  single-cycle pulse, loads seed; honoured only in IDLE.
- in_bit  input  1  data bit to scramble.
- in_valid  input  1  in_bit valid.
- in_ready  output  1  block accepts in_bit this cycle.
- out_bit  output  1  scrambled bit.
- out_valid  output  1  out_bit valid.
- out_ready  input  1  downstream accepts out_bit.
- busy  output  1  high in WARMUP and RUN.
- done  output  1  one-cycle pulse after SEQ_LEN-th bit accepted.

## Operation

- Two 31-bit shift registers, bit 0 = current x(n); each advance shifts right and writes feedback into bit 30.
- x1 feedback = x1[3] ^ x1[0]; x2 feedback = x2[3] ^ x2[2] ^ x2[1] ^ x2[0].
- On seed_valid in IDLE: x1 <= 31'h0000_0001, x2 <= seed, counter <= 0.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE -> WARMUP on seed_valid (NC > 0); IDLE -> RUN directly if NC == 0.
  - WARMUP: both registers advance every cycle; after NC advances -> RUN.
  - RUN: on accept (in_valid & in_ready), out_bit <= in_bit ^ x1[0] ^ x2[0]; both registers advance; counter increments. After SEQ_LEN-th accept -> IDLE, done pulses.
- Counter is 11 bits (wide enough for max(NC, SEQ_LEN) - 1 with default parameters); compares use exact terminal values, so there is no wrap.
- Registers do not advance in IDLE; this saves power.
- seed_valid in WARMUP or RUN is ignored; the sequence in progress is unaffected.
- Output stage is a single register with valid/ready handshake.
  - in_ready = (state == RUN) & (!out_valid | out_ready).
  - out_valid clears when out_ready is high and no new accept occurs in the same cycle.
- The last output bit may still be pending in the output register after return to IDLE. It drains normally.
- Reset values: state IDLE, x1 = 0, x2 = 0, counter = 0, out_bit = 0, out_valid = 0, done = 0, busy = 0, in_ready = 0.
- rst asserted mid-operation aborts immediately to reset values. Any pending output is discarded.

## Timing

- seed_valid at cycle T: WARMUP occupies cycles T+1 .. T+NC; in_ready is first high at T+1+NC. With NC = 0, in_ready is first high at T+1.
- Latency: accept at cycle k -> out_valid/out_bit visible at k+1.
- Full throughput is one bit per cycle while out_ready is held high.
- done is high during the cycle after the final accept, coincident with the last out_valid.
- busy is registered and follows the state.

## Configuration

- SCR_SEQ_OUT_EN defined: adds output port gold_bit (1 bit). gold_bit is registered alongside out_bit and carries x1[0] ^ x2[0] of each accepted bit. This lets the bench check the receiver-side LFSR bit-for-bit.
- SCR_SEQ_OUT_EN undefined: the gold_bit port and its register are absent. All other behaviour is identical.

## Test plan

- NC = 0, seed = 0, in_bit = 0 streamed, out_ready = 1 -> out bits n = 0..33 are 1, then 30 zeros, then 1 at n = 31, then 0, 0.
- NC = 0, seed = 31'h1, in_bit = 0 -> first 33 out bits are all 0. Repeat with in_bit = 1 -> all 1.
- Default NC = 1600, seed_valid at cycle 10 -> in_ready low through cycle 1610, high at 1611; busy high from cycle 11.
- Full SEQ_LEN = 1920 run, random in_valid/out_ready stalls -> exactly 1920 outputs, matching a golden model; done pulses once, with the last out_valid; state returns to IDLE.
- seed_valid re-pulsed mid-RUN -> output sequence unchanged versus the undisturbed run.
- rst asserted at bit 500 -> out_valid/busy/in_ready drop to 0 immediately. A new seed afterwards restarts from n = 0 with the correct sequence.
